// File: rtl/alu_div_if.sv
// alu_div_if -- request/result bundle between the execute-stage sequencer and
// the iterative divider.
//   master : drives start/abort/signed_op/wide/dividend/divisor, sees results
//   slave  : the divider; drives busy/done/div_error/quotient/remainder
interface alu_div_if #(
   parameter int WIDTH = 16
);
   logic               start;
   logic               abort;
   logic               signed_op;
   logic               wide;
   logic [2*WIDTH-1:0] dividend;
   logic [WIDTH-1:0]   divisor;
   logic               busy;
   logic               done;
   logic               div_error;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;

   modport master (
      output start, abort, signed_op, wide, dividend, divisor,
      input  busy, done, div_error, quotient, remainder
   );

   modport slave (
      input  start, abort, signed_op, wide, dividend, divisor,
      output busy, done, div_error, quotient, remainder
   );
endinterface

// File: rtl/alu_div.sv
// alu_div -- restoring signed/unsigned divider, one quotient bit per cycle.
// Double-width dividend over single-width divisor; N = WIDTH (wide) or WIDTH/2.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_div_if.slave: start/abort/signed_op/wide/dividend/divisor in,
//            busy/done/div_error/quotient/remainder out (all registered)
// Flow: IDLE/DONE -start-> SETUP -> ITER (N cycles) -> FIXUP -> DONE.
// SETUP jumps straight to DONE on divide-by-zero or unsigned-range overflow.
module alu_div #(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     reset_n,
   alu_div_if.slave bus
);
   localparam int W  = WIDTH;
   localparam int HW = WIDTH / 2;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_W = CW'(W - 1);
   localparam logic [CW-1:0] LAST_H = CW'(HW - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIXUP, S_DONE} state_t;
   state_t state, state_nxt;

   // latched request
   logic [2*W-1:0] dvd_r;
   logic [W-1:0]   dvs_r;
   logic           sgn_r, wide_r;
   // working state
   logic [W-1:0]   rem_r;      // partial remainder, always < divisor
   logic [W-1:0]   q_r;        // dividend low bits shift out, quotient bits shift in
   logic [W-1:0]   dvs_q;      // divisor magnitude
   logic           qneg_r, rneg_r;
   logic [CW-1:0]  cnt_r;
   // registered outputs
   logic           err_r;
   logic [W-1:0]   quo_o, rem_o;

   logic           accept;
   // SETUP datapath
   logic [2*W-1:0] dvd_x, dvd_mag, dvd_hi;
   logic [W-1:0]   dvs_x, dvs_mag, q_init;
   logic           dvd_neg, dvs_neg, setup_err;
   // ITER datapath
   logic           next_bit, take;
   logic [W:0]     rem_sh;
   logic [W-1:0]   rem_dif;
   logic           iter_last;
   // FIXUP datapath
   logic [W-1:0]   mask, top, q_mag, r_mag, q_fix, r_fix;
   logic           ovf;

   assign accept = (state == S_IDLE || state == S_DONE) && bus.start && !bus.abort;

   // Narrow operands are sign/zero-extended to full width so one magnitude
   // path serves both modes.
   always_comb begin
      dvd_x = dvd_r;
      dvs_x = dvs_r;
      if (!wide_r) begin
         dvd_x = sgn_r ? {{W{dvd_r[W-1]}}, dvd_r[W-1:0]} : {{W{1'b0}}, dvd_r[W-1:0]};
         dvs_x = sgn_r ? {{HW{dvs_r[HW-1]}}, dvs_r[HW-1:0]} : {{HW{1'b0}}, dvs_r[HW-1:0]};
      end
      dvd_neg   = sgn_r & dvd_x[2*W-1];
      dvs_neg   = sgn_r & dvs_x[W-1];
      dvd_mag   = dvd_neg ? -dvd_x : dvd_x;
      dvs_mag   = dvs_neg ? -dvs_x : dvs_x;
      dvd_hi    = wide_r ? (dvd_mag >> W) : (dvd_mag >> HW);
      // high half >= divisor means the quotient cannot fit in N bits
      setup_err = (dvs_mag == '0) || (dvd_hi >= {{W{1'b0}}, dvs_mag});
      q_init    = wide_r ? dvd_mag[W-1:0] : {{HW{1'b0}}, dvd_mag[HW-1:0]};
   end

   always_comb begin
      next_bit  = wide_r ? q_r[W-1] : q_r[HW-1];
      rem_sh    = {rem_r, next_bit};
      take      = rem_sh >= {1'b0, dvs_q};
      // true difference is < divisor, so W bits hold it exactly
      rem_dif   = rem_sh[W-1:0] - dvs_q;
      iter_last = cnt_r == (wide_r ? LAST_W : LAST_H);
   end

   always_comb begin
      mask  = wide_r ? {W{1'b1}} : {{HW{1'b0}}, {HW{1'b1}}};
      top   = (mask >> 1) + W'(1);               // 2^(N-1)
      q_mag = q_r & mask;                        // drop dividend bits shifted past N
      r_mag = rem_r & mask;
      q_fix = (qneg_r ? -q_mag : q_mag) & mask;
      r_fix = (rneg_r ? -r_mag : r_mag) & mask;
      ovf   = sgn_r && (qneg_r ? (q_mag > top) : (q_mag >= top));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_SETUP;
            S_SETUP: state_nxt = setup_err ? S_DONE : S_ITER;
            S_ITER:  if (iter_last) state_nxt = S_FIXUP;
            S_FIXUP: state_nxt = S_DONE;
            S_DONE:  state_nxt = bus.start ? S_SETUP : S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         S_SETUP, S_ITER, S_FIXUP: bus.busy = 1'b1;
         S_DONE:                   bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.div_error = err_r;
   assign bus.quotient  = quo_o;
   assign bus.remainder = rem_o;

   // Results land on the FIXUP->DONE edge so they are visible in the done cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dvd_r  <= '0;
         dvs_r  <= '0;
         sgn_r  <= 1'b0;
         wide_r <= 1'b0;
         rem_r  <= '0;
         q_r    <= '0;
         dvs_q  <= '0;
         qneg_r <= 1'b0;
         rneg_r <= 1'b0;
         cnt_r  <= '0;
         err_r  <= 1'b0;
         quo_o  <= '0;
         rem_o  <= '0;
      end else if (accept) begin
         dvd_r  <= bus.dividend;
         dvs_r  <= bus.divisor;
         sgn_r  <= bus.signed_op;
         wide_r <= bus.wide;
         err_r  <= 1'b0;
      end else if (!bus.abort) begin
         unique case (state)
            S_SETUP: begin
               rem_r  <= dvd_hi[W-1:0];
               q_r    <= q_init;
               dvs_q  <= dvs_mag;
               qneg_r <= dvd_neg ^ dvs_neg;
               rneg_r <= dvd_neg;
               cnt_r  <= '0;
               if (setup_err) err_r <= 1'b1;
            end
            S_ITER: begin
               rem_r <= take ? rem_dif : rem_sh[W-1:0];
               q_r   <= {q_r[W-2:0], take};
               cnt_r <= cnt_r + CW'(1);
            end
            S_FIXUP: begin
               if (ovf) begin
                  err_r <= 1'b1;
               end else begin
                  quo_o <= q_fix;
                  rem_o <= r_fix;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div -- randomized + directed bench for alu_div (WIDTH=16) with a
// cycle-level reference model built from integer division.
module tb_alu_div;
   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   alu_div_if #(.WIDTH(WIDTH)) bus ();
   alu_div #(.WIDTH(WIDTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   // reference: plain integer division, truncating toward zero
   function automatic void model(input bit sg, input bit wd, input logic [31:0] dd,
                                 input logic [15:0] dv, output bit err, output bit early,
                                 output logic [15:0] q, output logic [15:0] r);
      int     n;
      longint a, b, qq, rr, absq, lim, mask;
      n    = wd ? 16 : 8;
      mask = (longint'(1) << n) - 1;
      lim  = longint'(1) << (n - 1);
      if (sg) begin
         a = wd ? longint'($signed(dd)) : longint'($signed(dd[15:0]));
         b = wd ? longint'($signed(dv)) : longint'($signed(dv[7:0]));
      end else begin
         a = wd ? longint'(dd) : longint'(dd[15:0]);
         b = wd ? longint'(dv) : longint'(dv[7:0]);
      end
      q = '0;
      r = '0;
      if (b == 0) begin
         err   = 1'b1;
         early = 1'b1;
      end else begin
         qq    = a / b;
         rr    = a % b;
         absq  = (qq < 0) ? -qq : qq;
         early = absq >= (longint'(1) << n);
         err   = early || (sg && (qq > lim - 1 || qq < -lim));
         q     = 16'(qq & mask);
         r     = 16'(rr & mask);
      end
   endfunction

   // expected outputs for the current cycle, plus the result pending at done
   int          m_left = 0;
   bit          m_done = 1'b0;
   bit          m_err  = 1'b0;
   logic [15:0] m_q = '0, m_r = '0;
   bit          p_err = 1'b0;
   logic [15:0] p_q = '0, p_r = '0;

   initial begin : scoreboard
      bit early;
      forever begin
         @(negedge clk);
         checks++;
         if (!reset_n) begin
            if ({bus.busy, bus.done, bus.div_error, bus.quotient, bus.remainder} !== 35'h0) begin
               failures++;
               $display("FAIL sb_reset t=%0t busy=%b done=%b err=%b q=%h r=%h (need all 0)",
                        $time, bus.busy, bus.done, bus.div_error, bus.quotient, bus.remainder);
            end
         end else if (bus.busy !== (m_left > 0) || bus.done !== m_done || bus.div_error !== m_err ||
                      bus.quotient !== m_q || bus.remainder !== m_r) begin
            failures++;
            $display("FAIL sb t=%0t busy=%b/%b done=%b/%b err=%b/%b q=%h/%h r=%h/%h (got/need)",
                     $time, bus.busy, (m_left > 0), bus.done, m_done, bus.div_error, m_err,
                     bus.quotient, m_q, bus.remainder, m_r);
         end
         @(posedge clk);
         if (!reset_n) begin
            m_left = 0; m_done = 0; m_err = 0; m_q = '0; m_r = '0;
         end else begin
            m_done = 1'b0;
            if (bus.abort) begin
               m_left = 0;
            end else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1'b1;
                  m_err  = p_err;
                  if (!p_err) begin m_q = p_q; m_r = p_r; end
               end
            end else if (bus.start) begin
               model(bus.signed_op, bus.wide, bus.dividend, bus.divisor, p_err, early, p_q, p_r);
               m_left = early ? 1 : (bus.wide ? 16 : 8) + 2;
               m_err  = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   // Issue one op. b2b: called at the negedge of a done cycle, start lands in
   // that same cycle. noise: random start pulses/operand churn while busy.
   // cyc = done cycle counted from the accept edge (SETUP is cycle 1).
   task automatic run_op(input bit sg, input bit wd, input logic [31:0] dd, input logic [15:0] dv,
                         input bit b2b, input bit noise, output int cyc, output int nbusy);
      if (b2b) #2;
      else tick();
      bus.start = 1'b1; bus.signed_op = sg; bus.wide = wd; bus.dividend = dd; bus.divisor = dv;
      tick();
      bus.start = 1'b0; bus.signed_op = 1'($urandom); bus.wide = 1'($urandom);
      bus.dividend = $urandom; bus.divisor = 16'($urandom);
      cyc = -1;
      nbusy = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) begin cyc = k; break; end
         if (bus.busy) nbusy++;
         bus.start = noise ? 1'($urandom) : 1'b0;
         if (noise) begin bus.dividend = $urandom; bus.divisor = 16'($urandom); end
      end
      bus.start = 1'b0;
      checks++;
      if (cyc < 0) begin
         failures++;
         $display("FAIL op_timeout: no done within 40 cycles, need one (sg=%0d wide=%0d dd=%h dv=%h)",
                  sg, wd, dd, dv);
      end
   endtask

   initial begin : driver
      int          c, nb;
      bit          at_done;
      logic [31:0] x, dd;
      logic [15:0] dv;

      bus.start = 0; bus.abort = 0; bus.signed_op = 0; bus.wide = 0;
      bus.dividend = '0; bus.divisor = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {bus.busy, bus.done, bus.div_error, bus.quotient, bus.remainder}, 64'h0);
      tick();
      reset_n = 1'b1;
      tick();

      // unsigned word
      run_op(0, 1, 32'h0001_0000, 16'h0003, 0, 0, c, nb);
      chk("uw_latency", c, 19);
      chk("uw_busy_cycles", nb, 18);
      chk("uw_result", {bus.div_error, bus.quotient, bus.remainder}, {1'b0, 16'h5555, 16'h0001});

      // signed byte, upper operand bits are don't-care
      run_op(1, 0, 32'hABCD_FF9C, 16'h5A07, 0, 0, c, nb);
      chk("sb_latency", c, 11);
      chk("sb_result", {bus.div_error, bus.quotient, bus.remainder}, {1'b0, 16'h00F2, 16'h00FE});

      // divide by zero keeps prior results
      run_op(0, 1, 32'h091A_5678, 16'h8000, 0, 0, c, nb);
      chk("prior_result", {bus.quotient, bus.remainder}, {16'h1234, 16'h5678});
      run_op(0, 1, 32'h0000_0010, 16'h0000, 0, 0, c, nb);
      chk("dz_latency", c, 2);
      chk("dz_result", {bus.div_error, bus.quotient, bus.remainder}, {1'b1, 16'h1234, 16'h5678});

      // overflow cases
      run_op(0, 1, 32'h0002_0000, 16'h0001, 0, 0, c, nb);
      chk("uovf_latency", c, 2);
      chk("uovf_err", bus.div_error, 1);
      run_op(1, 1, 32'h0000_8000, 16'h0001, 0, 0, c, nb);
      chk("sovf_latency", c, 19);
      chk("sovf_err", {bus.div_error, bus.quotient}, {1'b1, 16'h1234});
      run_op(1, 1, 32'hFFFF_8000, 16'h0001, 0, 0, c, nb);
      chk("smin_result", {bus.div_error, bus.quotient, bus.remainder}, {1'b0, 16'h8000, 16'h0000});

      // abort in cycle 5
      tick();
      bus.start = 1; bus.signed_op = 0; bus.wide = 1; bus.dividend = 32'h0000_1234; bus.divisor = 16'h0007;
      tick();
      bus.start = 0;
      repeat (4) tick();
      bus.abort = 1;
      tick();
      bus.abort = 0;
      chk("abort_idle", {bus.busy, bus.done, bus.quotient, bus.remainder}, {2'b00, 16'h8000, 16'h0000});
      nb = 0;
      repeat (20) begin @(negedge clk); if (bus.done) nb++; end
      chk("abort_no_done", nb, 0);
      run_op(0, 1, 32'h0000_0064, 16'h000A, 0, 0, c, nb);
      chk("post_abort", {c[7:0], bus.div_error, bus.quotient, bus.remainder}, {8'd19, 1'b0, 16'h000A, 16'h0000});

      // reset mid-ITER
      tick();
      bus.start = 1; bus.signed_op = 1; bus.wide = 1; bus.dividend = 32'h0000_7777; bus.divisor = 16'h0011;
      tick();
      bus.start = 0;
      repeat (5) tick();
      #1 reset_n = 1'b0;
      #1 chk("reset_mid_iter", {bus.busy, bus.done, bus.div_error, bus.quotient, bus.remainder}, 64'h0);
      tick();
      tick();
      reset_n = 1'b1;

      // back-to-back with ignored start pulses in the second op
      run_op(0, 0, 32'h0000_03E8, 16'h0007, 0, 0, c, nb);
      chk("b2b_first", {c[7:0], bus.quotient, bus.remainder}, {8'd11, 16'h008E, 16'h0006});
      run_op(1, 1, 32'hFFFF_FFF9, 16'h0002, 1, 1, c, nb);
      chk("b2b_latency", c, 19);
      chk("b2b_result", {bus.div_error, bus.quotient, bus.remainder}, {1'b0, 16'hFFFD, 16'hFFFF});

      // random ops, aborts and back-to-back starts
      at_done = 1'b1;
      for (int i = 0; i < 250; i++) begin
         x = $urandom;
         case ($urandom % 4)
            0:       dd = x;
            1:       dd = {16'h0000, x[15:0]};
            2:       dd = {16'hFFFF, x[15:0]};
            default: dd = {8'h00, x[23:0]};
         endcase
         case ($urandom % 8)
            0:       dv = 16'h0000;
            1, 2:    dv = 16'($urandom_range(1, 15));
            3:       dv = {8'hFF, 8'($urandom)};
            default: dv = 16'($urandom);
         endcase
         if ($urandom % 8 == 0) begin
            tick();
            bus.start = 1; bus.signed_op = 1'($urandom); bus.wide = 1'($urandom);
            bus.dividend = dd; bus.divisor = dv;
            tick();
            bus.start = 0;
            repeat ($urandom_range(0, 20)) tick();
            bus.abort = 1;
            bus.start = 1'($urandom);
            tick();
            bus.abort = 0;
            bus.start = 0;
            at_done = 1'b0;
         end else begin
            run_op(1'($urandom), 1'($urandom), dd, dv, at_done && ($urandom % 3 == 0),
                   1'($urandom), c, nb);
            at_done = (c > 0);
         end
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
